qr_out_reorder: RTL

- Sits directly downstream of the 4x4 CORDIC QR array.
- Captures each 16-cycle burst of paired R/Q results, which arrive in row-major order with k = row*4+col.
- Stores each burst in one of two ping-pong register banks.
- Drains each stored matrix to the next stage in column-major order over a valid/ready handshake, flagging truncated bursts, dropped bursts and non-zero sub-diagonal R entries.

---
 rtl/qr_out_reorder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/qr_out_reorder.sv
// Ping-pong capture of row-major 4x4 QR result bursts, drained column-major over valid/ready.
// Flags truncated bursts, dropped bursts and non-zero sub-diagonal R entries.
module qr_out_reorder #(
   parameter int DIM       = 4,
   parameter int R_WIDTH   = 12,
   parameter int Q_WIDTH   = 12,
   parameter int IDX_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [R_WIDTH-1:0]   in_r,
   input  logic [Q_WIDTH-1:0]   in_q,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [R_WIDTH-1:0]   m_r,
   output logic [Q_WIDTH-1:0]   m_q,
   output logic [IDX_WIDTH-1:0] m_idx,
   output logic                 m_last,
   output logic [1:0]           banks_full,
   output logic                 overflow,
   output logic                 tri_err,
   output logic                 trunc_err,
   input  logic                 clr_err
);
   // state | meaning
   // IDLE  | waiting for element 0 of a burst
   // CAPT  | storing elements 1..15 into bank wb
   // DROP  | no free bank; discarding until in_valid falls
   typedef enum logic [1:0] {IDLE, CAPT, DROP} wr_state_t;

   localparam int DEPTH = DIM * DIM;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

   wr_state_t            state;
   logic [R_WIDTH-1:0]   bank_r [2][DEPTH];
   logic [Q_WIDTH-1:0]   bank_q [2][DEPTH];
   logic [1:0]           full;
   logic [1:0]           full_nxt;
   logic                 wb, rb;
   logic [IDX_WIDTH-1:0] wr_cnt, rd_cnt, rd_addr;
   logic                 rel, wb_free, wr_en, cap_done, tri_set, acc;

   // Column-major drain: row = c%4, col = c/4, so the address swaps the two index halves.
   assign rd_addr    = {rd_cnt[1:0], rd_cnt[3:2]};
   assign m_valid    = full[rb];
   assign m_r        = bank_r[rb][rd_addr];
   assign m_q        = bank_q[rb][rd_addr];
   assign m_idx      = rd_addr;
   assign m_last     = m_valid && (rd_cnt == LAST_IDX);
   assign banks_full = {1'b0, full[0]} + {1'b0, full[1]};

   always_comb begin
      acc      = m_valid && m_ready;
      rel      = acc && (rd_cnt == LAST_IDX);
      // A bank released by this cycle's final handshake can be reused immediately.
      wb_free  = !full[wb] || (rel && (rb == wb));
      wr_en    = in_valid && (((state == IDLE) && wb_free) || (state == CAPT));
      cap_done = in_valid && (state == CAPT) && (wr_cnt == LAST_IDX);
      tri_set  = wr_en && (wr_cnt[3:2] > wr_cnt[1:0]) && (in_r != '0);
      full_nxt = full;
      if (rel)      full_nxt[rb] = 1'b0;
      if (cap_done) full_nxt[wb] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         full      <= '0;
         wb        <= 1'b0;
         rb        <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         overflow  <= 1'b0;
         tri_err   <= 1'b0;
         trunc_err <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               bank_r[b][i] <= '0;
               bank_q[b][i] <= '0;
            end
         end
      end else begin
         full      <= full_nxt;
         trunc_err <= (state == CAPT) && !in_valid;
         overflow  <= (overflow && !clr_err) || ((state == IDLE) && in_valid && !wb_free);
         tri_err   <= (tri_err && !clr_err) || tri_set;

         if (rel) begin
            rb     <= ~rb;
            rd_cnt <= '0;
         end else if (acc) begin
            rd_cnt <= rd_cnt + 1'b1;
         end

         if (wr_en) begin
            bank_r[wb][wr_cnt] <= in_r;
            bank_q[wb][wr_cnt] <= in_q;
         end

         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (wb_free) begin
                     state  <= CAPT;
                     wr_cnt <= wr_cnt + 1'b1;
                  end else begin
                     state <= DROP;
                  end
               end
            end
            CAPT: begin
               if (!in_valid) begin
                  wr_cnt <= '0;
                  state  <= IDLE;
               end else if (wr_cnt == LAST_IDX) begin
                  wb     <= ~wb;
                  wr_cnt <= '0;
                  state  <= IDLE;
               end else begin
                  wr_cnt <= wr_cnt + 1'b1;
               end
            end
            DROP: begin
               if (!in_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
